ram_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port block RAM IP. It sits between two internal masters and the RAM's en/we/addr/din/dout port, and serializes their accesses with a round-robin grant. It routes read data back to the issuing master through a latency-matched tag pipeline. After reset it can sweep the RAM to zero before accepting traffic.

---
 rtl/ram_arb.sv | 133 +++++++++++++
 tb/tb_ram_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter/sequencer between two masters and one single-port block RAM.
// Optional feature: define RAM_ARB_INIT_CLEAR_EN to sweep the RAM to zero after every reset.
module ram_arb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t state, state_next;

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;
  logic              last_gnt;
  logic              gnt_id;
  logic              elig0, elig1, grant, win;
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_id;

  // A req seen while its own ack is high belongs to the access just issued.
  always_comb begin
    sweep_last = (sweep_addr == {ADDR_W{1'b1}});
    elig0      = init_done & m0_req & ~m0_ack;
    elig1      = init_done & m1_req & ~m1_ack;
    grant      = elig0 | elig1;
    win        = (elig0 & elig1) ? ~last_gnt : elig1;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_last) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= RESET_STATE;
    else         state <= state_next;
  end

  // RAM command register: clear sweep in INIT, registered winner in RUN.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sweep_addr <= '0;
      init_done  <= 1'b0;
      last_gnt   <= 1'b1;
      gnt_id     <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      init_done <= (state == RUN);
      m0_ack    <= grant & ~win;
      m1_ack    <= grant & win;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      if (state == INIT) begin
        ram_en     <= 1'b1;
        ram_we     <= 1'b1;
        ram_addr   <= sweep_addr;
        sweep_addr <= sweep_addr + 1'b1;
      end else if (grant) begin
        ram_en   <= 1'b1;
        ram_we   <= win ? m1_we    : m0_we;
        ram_addr <= win ? m1_addr  : m0_addr;
        ram_din  <= win ? m1_wdata : m0_wdata;
        gnt_id   <= win;
        last_gnt <= win;
      end
    end
  end

  // Tag pipeline matched to the RAM read latency; its exit registers ram_dout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      tag_valid[0] <= ram_en & ~ram_we;
      tag_id[0]    <= gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      m0_rvalid <= tag_valid[RD_LAT-1] & ~tag_id[RD_LAT-1];
      m1_rvalid <= tag_valid[RD_LAT-1] &  tag_id[RD_LAT-1];
      if (tag_valid[RD_LAT-1] & ~tag_id[RD_LAT-1]) m0_rdata <= ram_dout;
      if (tag_valid[RD_LAT-1] &  tag_id[RD_LAT-1]) m1_rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: self-checking bench for ram_arb with a behavioural RAM and a transaction-level model.
// Works with or without RAM_ARB_INIT_CLEAR_EN defined.
module tb_ram_arb;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam int INIT_R = DEPTH + 1;
`else
  localparam int INIT_R = 1;
`endif

  logic              sys_clk;
  logic              sys_rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m0_rvalid, m1_ack, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic              init_done;
  logic              ram_fill;

  logic [DATA_W-1:0] ram_mem [0:DEPTH-1];

  ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .init_done(init_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Single-port RAM with one cycle of read latency; ram_fill loads a known pattern.
  always @(posedge sys_clk) begin
    if (ram_fill) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DATA_W'(i * 7 + 3);
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;

  typedef struct {
    int                m;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  r_cnt  = 0;
  bit  exp_ack0, exp_ack1, exp_last, prev_active;
  logic [DATA_W-1:0] image [0:DEPTH-1];
  logic [DATA_W-1:0] exp_rd0, exp_rd1;
  rd_t q0[$];
  rd_t q1[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle reference: round-robin grant on eligible requests, memory image, read return queues.
  task automatic monitor();
    bit  e0, e1, w, a0, a1, x0, x1, sweeping;
    rd_t t;
    cyc++;
    if (sys_rst) begin
      check_output("reset_outputs",
        64'({m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
             ram_en, ram_we, ram_addr, ram_din, init_done}), 64'd0);
      r_cnt = 0; exp_ack0 = 0; exp_ack1 = 0; exp_last = 1; prev_active = 0;
      q0.delete(); q1.delete();
      exp_rd0 = '0; exp_rd1 = '0;
      return;
    end
    if (r_cnt < 1000000) r_cnt++;
    check_output("init_done", 64'(init_done), 64'(r_cnt >= INIT_R));
    e0 = prev_active && m0_req && !exp_ack0;
    e1 = prev_active && m1_req && !exp_ack1;
    w  = (e0 && e1) ? !exp_last : e1;
    a0 = (e0 || e1) && !w;
    a1 = (e0 || e1) && w;
    if (e0 || e1) exp_last = w;
    check_output("ack", 64'({m0_ack, m1_ack}), 64'({a0, a1}));
    sweeping = 0;
`ifdef RAM_ARB_INIT_CLEAR_EN
    if (r_cnt <= DEPTH) begin
      sweeping = 1;
      check_output("sweep_bus", 64'({ram_en, ram_we, ram_addr, ram_din}),
                   64'({1'b1, 1'b1, ADDR_W'(r_cnt - 1), DATA_W'(0)}));
      image[r_cnt-1] = '0;
    end
`endif
    if (!sweeping) check_output("ram_en", 64'(ram_en), 64'(a0 | a1));
    if (a0) begin
      check_output("m0_cmd", 64'({ram_we, ram_addr}), 64'({m0_we, m0_addr}));
      if (m0_we) begin
        check_output("m0_din", 64'(ram_din), 64'(m0_wdata));
        image[m0_addr] = m0_wdata;
      end else q0.push_back('{data: image[m0_addr], due: cyc + RD_LAT + 1});
    end
    if (a1) begin
      check_output("m1_cmd", 64'({ram_we, ram_addr}), 64'({m1_we, m1_addr}));
      if (m1_we) begin
        check_output("m1_din", 64'(ram_din), 64'(m1_wdata));
        image[m1_addr] = m1_wdata;
      end else q1.push_back('{data: image[m1_addr], due: cyc + RD_LAT + 1});
    end
    x0 = (q0.size() != 0) && (q0[0].due == cyc);
    x1 = (q1.size() != 0) && (q1[0].due == cyc);
    if (x0) begin t = q0.pop_front(); exp_rd0 = t.data; end
    if (x1) begin t = q1.pop_front(); exp_rd1 = t.data; end
    check_output("rvalid", 64'({m0_rvalid, m1_rvalid}), 64'({x0, x1}));
    check_output("rdata", 64'({m0_rdata, m1_rdata}), 64'({exp_rd0, exp_rd1}));
    exp_ack0 = a0; exp_ack1 = a1;
    prev_active = (r_cnt >= INIT_R);
  endtask

  task automatic step();
    @(negedge sys_clk);
    monitor();
  endtask

  task automatic drive_master(input int k, input logic r, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (k == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  function automatic logic get_ack(input int k);
    return (k == 0) ? m0_ack : m1_ack;
  endfunction

  task automatic apply_stimulus(input int k, input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, output int lat);
    drive_master(k, 1'b1, we, a, d);
    lat = 0;
    do begin step(); lat++; end while (!get_ack(k) && lat < 20);
    if (!get_ack(k)) check_output("ack_timeout", 64'd0, 64'd1);
    drive_master(k, 1'b0, we, a, d);
  endtask

  task automatic wait_rvalid(input int k, output int lat, output logic [DATA_W-1:0] data);
    logic rv;
    lat = 0;
    do begin
      step(); lat++;
      rv = (k == 0) ? m0_rvalid : m1_rvalid;
    end while (!rv && lat < 10);
    if (!rv) check_output("rvalid_timeout", 64'd0, 64'd1);
    data = (k == 0) ? m0_rdata : m1_rdata;
  endtask

  task automatic wait_init();
    int n = 0;
    do begin step(); n++; end while (!init_done && n < 40);
    check_output("init_done_reached", 64'(init_done), 64'd1);
  endtask

  task automatic do_reset();
    m0_req = 0; m1_req = 0; sys_rst = 1;
    repeat (3) step();
    sys_rst = 0;
    wait_init();
  endtask

  // Retire pending requests, each dropped on its own ack, then let reads return.
  task automatic finish_reqs();
    if (m0_ack) m0_req = 0;
    if (m1_ack) m1_req = 0;
    for (int n = 0; n < 10 && (m0_req || m1_req); n++) begin
      step();
      if (m0_ack) m0_req = 0;
      if (m1_ack) m1_req = 0;
    end
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int lat, n, rv0, rv1, rvc;
    logic [DATA_W-1:0] data, d0, d1;

    vecs[0] = '{0, 1'b1, 5'd3,  8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 5'd3,  8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 5'd3,  8'h5A, 8'h00};
    vecs[3] = '{0, 1'b0, 5'd3,  8'h00, 8'h5A};
    vecs[4] = '{1, 1'b1, 5'd0,  8'hC3, 8'h00};
    vecs[5] = '{1, 1'b0, 5'd0,  8'h00, 8'hC3};
    vecs[6] = '{0, 1'b1, 5'd31, 8'hFF, 8'h00};
    vecs[7] = '{1, 1'b0, 5'd31, 8'h00, 8'hFF};
    vecs[8] = '{0, 1'b1, 5'd7,  8'h00, 8'h00};
    vecs[9] = '{1, 1'b0, 5'd7,  8'h00, 8'h00};

    for (int i = 0; i < DEPTH; i++) image[i] = DATA_W'(i * 7 + 3);
    sys_rst = 1; ram_fill = 1;
    drive_master(0, 1'b0, 1'b0, '0, '0);
    drive_master(1, 1'b0, 1'b0, '0, '0);
    exp_last = 1;
    step(); step();
    ram_fill = 0;
    step();
    sys_rst = 0;

    $display("[TB] bring-up after reset");
`ifdef RAM_ARB_INIT_CLEAR_EN
    n = 0;
    do begin step(); n++; end while (!init_done && n < 40);
    check_output("init_latency", 64'(n), 64'(DEPTH + 1));
    apply_stimulus(0, 1'b0, 5'd7, 8'h00, lat);
    wait_rvalid(0, lat, data);
    check_output("cleared_rdata", 64'(data), 64'h00);
`else
    step();
    check_output("init_done_first_cycle", 64'(init_done), 64'd1);
    drive_master(0, 1'b1, 1'b0, 5'd7, 8'h00);
    step();
    check_output("first_req_ack", 64'({m0_ack, ram_en}), 64'b11);
    drive_master(0, 1'b0, 1'b0, 5'd7, 8'h00);
    repeat (3) step();
`endif

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check_output("ack_latency", 64'(lat), 64'd1);
      if (!vecs[i].we) begin
        wait_rvalid(vecs[i].m, lat, data);
        check_output("rvalid_latency", 64'(lat), 64'(RD_LAT + 1));
        check_output("table_rdata", 64'(data), 64'(vecs[i].rdata));
      end else step();
    end

    $display("[TB] back-to-back reads to both masters");
    do_reset();
    apply_stimulus(0, 1'b1, 5'd1, 8'h11, lat); step();
    apply_stimulus(1, 1'b1, 5'd2, 8'h22, lat); step();
    drive_master(0, 1'b1, 1'b0, 5'd1, 8'h00);
    drive_master(1, 1'b1, 1'b0, 5'd2, 8'h00);
    rv0 = -1; rv1 = -1; d0 = '0; d1 = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m0_ack) m0_req = 0;
      if (m1_ack) m1_req = 0;
      if (m0_rvalid && rv0 < 0) begin rv0 = k; d0 = m0_rdata; end
      if (m1_rvalid && rv1 < 0) begin rv1 = k; d1 = m1_rdata; end
    end
    check_output("b2b_m0_rdata", 64'(d0), 64'h11);
    check_output("b2b_m1_rdata", 64'(d1), 64'h22);
    check_output("b2b_order", 64'(rv1 - rv0), 64'd1);

    $display("[TB] both masters held continuously");
    do_reset();
    drive_master(0, 1'b1, 1'b0, 5'd4, 8'h00);
    drive_master(1, 1'b1, 1'b0, 5'd5, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      check_output("alternate_ack", 64'({m0_ack, m1_ack}), (k % 2 == 0) ? 64'd2 : 64'd1);
    end
    finish_reqs();

    $display("[TB] reset with a read in flight");
    apply_stimulus(0, 1'b0, 5'd9, 8'h00, lat);
    step();
    sys_rst = 1;
    rvc = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (m0_rvalid || m1_rvalid) rvc++;
    end
    sys_rst = 0;
    step();
`ifdef RAM_ARB_INIT_CLEAR_EN
    check_output("sweep_restart", 64'({ram_en, ram_we, ram_addr, ram_din}), 64'({1'b1, 1'b1, 5'd0, 8'h00}));
`else
    check_output("post_reset_idle", 64'({ram_en, init_done}), 64'b01);
`endif
    check_output("no_rvalid_after_reset", 64'(rvc), 64'd0);
    wait_init();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 800; c++) begin
      step();
      if (m0_req && m0_ack) m0_req = 0;
      if (m1_req && m1_ack) m1_req = 0;
      if (!m0_req && $urandom_range(0, 2) == 0)
        drive_master(0, 1'b1, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, DEPTH - 1)),
                     DATA_W'($urandom));
      if (!m1_req && $urandom_range(0, 2) == 0)
        drive_master(1, 1'b1, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, DEPTH - 1)),
                     DATA_W'($urandom));
    end
    finish_reqs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
